// File: rtl/mag_power_ctrl.sv
// Magnetron power controller: IDLE/COOK/PAUSE/DONE sequencer with a level-selected
// duty cycle on mag and a combinational door interlock.
module mag_power_ctrl #(
  parameter int LVL_W = 2,
  parameter int SLOT  = 5,
  parameter int PH_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startn,
  input  logic             stopn,
  input  logic             clearn,
  input  logic             door_closed,
  input  logic             timer_done,
  input  logic [LVL_W-1:0] power_level,
  output logic             mag,
  output logic [1:0]       state,
  output logic             done
);

  localparam int LEVELS = 2 ** LVL_W;
  localparam int PERIOD = SLOT * LEVELS;
  localparam int CMP_W  = LVL_W + $clog2(SLOT) + 1;
  localparam int CW     = (CMP_W > PH_W) ? CMP_W : PH_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             startn_q;
  logic             door_q;

  logic             start_ev_s;
  logic             door_open_ev_s;
  logic [CW-1:0]    on_lim_s;
  logic [CW-1:0]    phase_ext_s;

  assign start_ev_s     = startn_q & ~startn;
  assign door_open_ev_s = door_q & ~door_closed;

  // State, phase, latched level and edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= {PH_W{1'b0}};
      lvl_q    <= {LVL_W{1'b0}};
      startn_q <= 1'b1;
      door_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      lvl_q    <= lvl_d;
      startn_q <= startn;
      door_q   <= door_closed;
    end
  end

  // Next-state logic; clear overrides every per-state rule
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    lvl_d   = lvl_q;
    if (!clearn) begin
      state_d = IDLE;
      phase_d = {PH_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ev_s && door_closed && stopn && !timer_done) begin
            state_d = COOK;
            phase_d = {PH_W{1'b0}};
            lvl_d   = power_level;
          end else begin
            state_d = IDLE;
          end
        end
        COOK: begin
          if (phase_q == PH_W'(PERIOD - 1)) begin
            phase_d = {PH_W{1'b0}};
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
          if (!stopn || !door_closed) begin
            state_d = PAUSE;
          end else if (timer_done) begin
            state_d = DONE;
          end else begin
            state_d = COOK;
          end
        end
        PAUSE: begin
          // Phase is held so a resume continues the same duty period
          if (timer_done) begin
            state_d = DONE;
          end else if (start_ev_s && door_closed && stopn) begin
            state_d = COOK;
            lvl_d   = power_level;
          end else begin
            state_d = PAUSE;
          end
        end
        DONE: begin
          if (door_open_ev_s) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = {PH_W{1'b0}};
        end
      endcase
    end
  end

  // On-window length is (level+1) slots; widened so the top level cannot overflow
  assign on_lim_s    = (CW'(lvl_q) + CW'(1)) * CW'(SLOT);
  assign phase_ext_s = CW'(phase_q);

  assign mag   = (state_q == COOK) && (phase_ext_s < on_lim_s) && door_closed;
  assign state = state_q;
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mag_power_ctrl.sv
// Directed and random bench for mag_power_ctrl; a behavioural model feeds a
// scoreboard queue that is checked against the DUT after every clock edge.
module tb_mag_power_ctrl;
  localparam int LVL_W  = 2;
  localparam int SLOT   = 5;
  localparam int PH_W   = 5;
  localparam int PERIOD = SLOT * (2 ** LVL_W);

  logic       clk = 1'b0;
  logic       rst, startn, stopn, clearn, door_closed, timer_done;
  logic [1:0] power_level;
  logic       mag, done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int mag_ones = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       mg;
    logic       dn;
  } exp_t;
  exp_t sbq[$];

  logic [1:0] m_state;
  int         m_phase, m_lvl;
  logic       m_startn_q, m_door_q;

  mag_power_ctrl #(.LVL_W(LVL_W), .SLOT(SLOT), .PH_W(PH_W)) dut (
    .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
    .mag(mag), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_mag();
    return (m_state == 2'd1) && (m_phase < (m_lvl + 1) * SLOT) && door_closed;
  endfunction

  // Reference model: one clock edge using the inputs currently applied
  task automatic model_edge();
    logic       sev;
    logic [1:0] ns;
    int         np, nl;
    if (rst) begin
      m_state = 2'd0; m_phase = 0; m_lvl = 0; m_startn_q = 1'b1; m_door_q = 1'b0;
      return;
    end
    sev = m_startn_q & ~startn;
    ns = m_state; np = m_phase; nl = m_lvl;
    if (!clearn) begin
      ns = 2'd0; np = 0;
    end else begin
      case (m_state)
        2'd0: if (sev && door_closed && stopn && !timer_done) begin
          ns = 2'd1; np = 0; nl = int'(power_level);
        end
        2'd1: begin
          np = (m_phase + 1) % PERIOD;
          if (!stopn || !door_closed) ns = 2'd2;
          else if (timer_done) ns = 2'd3;
        end
        2'd2: begin
          if (timer_done) ns = 2'd3;
          else if (sev && door_closed && stopn) begin
            ns = 2'd1; nl = int'(power_level);
          end
        end
        default: if (m_door_q && !door_closed) ns = 2'd0;
      endcase
    end
    m_state = ns; m_phase = np; m_lvl = nl;
    m_startn_q = startn; m_door_q = door_closed;
  endtask

  // One clock: model the edge, queue the prediction, then compare the DUT against it
  task automatic cyc();
    exp_t e, g;
    @(posedge clk);
    model_edge();
    #1;
    e.st = m_state; e.mg = exp_mag(); e.dn = (m_state == 2'd3);
    sbq.push_back(e);
    g = sbq.pop_front();
    check("sb_state", 32'(state), 32'(g.st));
    check("sb_mag", 32'(mag), 32'(g.mg));
    check("sb_done", 32'(done), 32'(g.dn));
    mag_ones += int'(mag);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0; power_level = 2'd1;
    m_state = 2'd0; m_phase = 0; m_lvl = 0; m_startn_q = 1'b1; m_door_q = 1'b0;

    // Reset
    cyc(); cyc();
    check("rst_state", 32'(state), 32'd0);
    check("rst_mag", 32'(mag), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // startn held low across reset release: exactly one start event
    startn = 1'b0; cyc();
    rst = 1'b0; cyc();
    stopn = 1'b0; cyc();
    stopn = 1'b1; cyc(); cyc(); cyc();
    check("held_start_single", 32'(state), 32'd2);
    startn = 1'b1; clearn = 1'b0; cyc();
    clearn = 1'b1; cyc();
    check("clear_to_idle", 32'(state), 32'd0);

    // Level 1 duty: 30 of 60 cycles
    power_level = 2'd1; startn = 1'b0; mag_ones = 0;
    cyc();
    check("start_cook", 32'(state), 32'd1);
    startn = 1'b1;
    repeat (59) cyc();
    check("duty_lvl1", 32'(mag_ones), 32'd30);

    // Full power, then door interlock
    clearn = 1'b0; cyc();
    clearn = 1'b1; power_level = 2'd3; startn = 1'b0; mag_ones = 0;
    cyc();
    startn = 1'b1;
    repeat (19) cyc();
    check("duty_full", 32'(mag_ones), 32'd20);
    repeat (4) cyc();
    door_closed = 1'b0;
    #1;
    check("door_comb_mag", 32'(mag), 32'd0);
    check("door_comb_state", 32'(state), 32'd1);
    cyc();
    check("door_pause", 32'(state), 32'd2);
    door_closed = 1'b1; cyc();
    power_level = 2'd0; startn = 1'b0; mag_ones = 0;
    cyc();
    check("resume_cook", 32'(state), 32'd1);
    startn = 1'b1;
    repeat (19) cyc();
    check("resume_lvl0_window", 32'(mag_ones), 32'd5);

    // Priority: stop beats start, clear beats start
    stopn = 1'b0; startn = 1'b0; cyc();
    check("stop_wins", 32'(state), 32'd2);
    stopn = 1'b1; cyc();
    check("no_second_edge", 32'(state), 32'd2);
    startn = 1'b1; cyc();
    clearn = 1'b0; startn = 1'b0; cyc();
    check("clear_wins", 32'(state), 32'd0);
    clearn = 1'b1; startn = 1'b1; cyc();

    // timer with stop in COOK: PAUSE then DONE
    power_level = 2'd1; startn = 1'b0; cyc();
    startn = 1'b1; stopn = 1'b0; timer_done = 1'b1; cyc();
    check("timer_stop_pause", 32'(state), 32'd2);
    cyc();
    check("timer_done_state", 32'(state), 32'd3);
    check("timer_done_flag", 32'(done), 32'd1);
    check("timer_done_mag", 32'(mag), 32'd0);
    stopn = 1'b1; startn = 1'b0; cyc();
    check("done_ignores_start", 32'(state), 32'd3);
    startn = 1'b1; door_closed = 1'b0; cyc();
    check("done_door_open", 32'(state), 32'd0);
    door_closed = 1'b1; timer_done = 1'b0; cyc();

    // COOK straight to DONE on timer, then clear
    startn = 1'b0; cyc();
    startn = 1'b1; cyc(); cyc();
    timer_done = 1'b1; cyc();
    check("cook_to_done", 32'(state), 32'd3);
    timer_done = 1'b0; clearn = 1'b0; cyc();
    check("done_clear", 32'(state), 32'd0);
    clearn = 1'b1; cyc();

    // Mid-COOK reset, then resume with a higher level
    power_level = 2'd2; startn = 1'b0; cyc();
    startn = 1'b1; repeat (3) cyc();
    rst = 1'b1; cyc();
    check("midcook_rst_state", 32'(state), 32'd0);
    check("midcook_rst_mag", 32'(mag), 32'd0);
    rst = 1'b0; cyc();
    check("no_pending_resume", 32'(state), 32'd0);
    power_level = 2'd0; startn = 1'b0; cyc();
    startn = 1'b1; repeat (6) cyc();
    stopn = 1'b0; cyc();
    stopn = 1'b1; power_level = 2'd2; startn = 1'b0; mag_ones = 0;
    cyc();
    startn = 1'b1;
    repeat (19) cyc();
    check("resume_lvl2_window", 32'(mag_ones), 32'd15);

    // Random soak with invariant checks
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      startn      = ($urandom_range(0, 9) < 7);
      stopn       = ($urandom_range(0, 9) != 0);
      clearn      = ($urandom_range(0, 19) != 0);
      door_closed = ($urandom_range(0, 9) != 0);
      timer_done  = ($urandom_range(0, 9) == 0);
      power_level = 2'($urandom_range(0, 3));
      cyc();
      check("inv_mag", 32'(mag && !(state == 2'd1 && door_closed)), 32'd0);
      check("inv_done", 32'(done), 32'(state == 2'd3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
